// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline control slice.
// Imported by the hazard sequencer and the load-use comparator.
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam int DEF_MDU_LATENCY = 4;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'b01,
    MDU_WAIT = 2'b10
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between ID operands and EX load.
// Shared with the forwarding unit.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_write_reg,
  output logic             hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == ex_write_reg);
  assign rt_hit = id_uses_rt && (id_rt == ex_write_reg);

  // $zero never carries a real dependency
  assign hazard = ex_mem_read
               && (ex_write_reg != REG_ZERO)
               && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the pipeline registers: load-use bubbles,
// EX redirects and multi-cycle MDU occupancy, plus perf counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MDU_LATENCY = DEF_MDU_LATENCY,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             clear_counters,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [WAIT_W-1:0] WAIT_INIT =
    WAIT_W'(MDU_LATENCY - 2);

  logic hazard;
  state_t state_q;
  state_t state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;

  load_use_detect u_lud (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_write_reg (ex_write_reg),
    .hazard       (hazard)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        if (!ex_redirect && ex_mdu_start) begin
          state_d = MDU_WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      MDU_WAIT: begin
        if (wait_q == '0) begin
          state_d = RUN;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mdu_busy    = 1'b0;
    mdu_done    = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          priority case (1'b1)
            ex_redirect: begin
              pc_en      = 1'b1;
              ifid_en    = 1'b1;
              ifid_flush = 1'b1;
              idex_en    = 1'b1;
              idex_flush = 1'b1;
            end
            ex_mdu_start: begin
              exmem_flush = 1'b1;
            end
            hazard: begin
              idex_en    = 1'b1;
              idex_flush = 1'b1;
            end
            default: begin
              pc_en   = 1'b1;
              ifid_en = 1'b1;
              idex_en = 1'b1;
            end
          endcase
        end
        MDU_WAIT: begin
          exmem_flush = 1'b1;
          mdu_busy    = 1'b1;
          mdu_done    = (wait_q == '0);
        end
        default: begin
          exmem_flush = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (clear_counters) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (ifid_flush && (flush_events != '1))
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a
// cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_write_reg;
  logic       ex_redirect;
  logic       ex_mdu_start;
  logic       clear_counters;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_flush;
  logic       exmem_flush;
  logic       mdu_busy;
  logic       mdu_done;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_events;

  int checks;
  int errors;

  int m_left;
  int m_stall;
  int m_flush;

  logic [7:0] obs;
  logic [7:0] exp_o;

  pipeline_hazard_ctrl #(
    .MDU_LATENCY (LAT),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .ex_mem_read    (ex_mem_read),
    .ex_write_reg   (ex_write_reg),
    .ex_redirect    (ex_redirect),
    .ex_mdu_start   (ex_mdu_start),
    .clear_counters (clear_counters),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .ifid_flush     (ifid_flush),
    .idex_en        (idex_en),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .mdu_busy       (mdu_busy),
    .mdu_done       (mdu_done),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
  );

  assign obs = {pc_en, ifid_en, ifid_flush, idex_en,
                idex_flush, exmem_flush, mdu_busy, mdu_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs, bit order as obs
  function automatic logic [7:0] model_out();
    bit dep;
    dep = ex_mem_read && (ex_write_reg != 0) &&
          ((id_uses_rs && id_rs == ex_write_reg) ||
           (id_uses_rt && id_rt == ex_write_reg));
    if (reset) return 8'b0000_0000;
    if (m_left > 0) return {7'b0000_011, m_left == 1};
    if (ex_redirect) return 8'b1111_1000;
    if (ex_mdu_start) return 8'b0000_0100;
    if (dep) return 8'b0001_1000;
    return 8'b1101_0000;
  endfunction

  task automatic model_tick();
    logic [7:0] e;
    e = model_out();
    if (reset) begin
      m_left = 0;
      m_stall = 0;
      m_flush = 0;
      return;
    end
    if (clear_counters) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!e[7] && m_stall < CMAX) m_stall++;
      if (e[5] && m_flush < CMAX) m_flush++;
    end
    if (m_left > 0) m_left--;
    else if (!ex_redirect && ex_mdu_start) m_left = LAT - 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_in();
    id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    ex_mem_read = 0; ex_write_reg = 0;
    ex_redirect = 0; ex_mdu_start = 0;
    clear_counters = 0;
  endtask

  task automatic clear_cnt();
    idle_in();
    clear_counters = 1;
    tick();
    clear_counters = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_in();
    m_left = 0; m_stall = 0; m_flush = 0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold obs=%b exp=%b", obs, 8'h00);
    end
    #1 reset = 0;
    #1;
    checks++;
    if (obs !== 8'b1101_0000) begin
      errors++;
      $display("FAIL reset_release obs=%b exp=%b", obs, 8'b1101_0000);
    end
    tick();
    ex_mem_read = 1; ex_write_reg = 5; id_rs = 5; id_uses_rs = 1;
    tick();
    tick();
    idle_in();
    @(negedge clk);
    #2 reset = 1;
    m_left = 0; m_stall = 0; m_flush = 0;
    #1;
    checks++;
    if (obs !== 8'h00 || stall_cycles !== 0 || flush_events !== 0) begin
      errors++;
      $display("FAIL reset_async obs=%b stall=%0d flush=%0d exp=0",
               obs, stall_cycles, flush_events);
    end
    tick();
    reset = 0;
    @(negedge clk);
    checks++;
    if (obs !== 8'b1101_0000 || stall_cycles !== 0) begin
      errors++;
      $display("FAIL reset_idle obs=%b stall=%0d exp=11010000/0",
               obs, stall_cycles);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_cnt();
    ex_mem_read = 1; ex_write_reg = 8; id_rs = 8; id_uses_rs = 1;
    @(negedge clk);
    exp_o = model_out();
    checks++;
    if (obs !== exp_o || pc_en !== 0 || ifid_en !== 0 || idex_flush !== 1) begin
      errors++;
      $display("FAIL load_use obs=%b exp=%b", obs, exp_o);
    end
    tick();
    idle_in();
    @(negedge clk);
    checks++;
    if (pc_en !== 1 || idex_flush !== 0 || stall_cycles !== 1) begin
      errors++;
      $display("FAIL load_use_after pc_en=%b stall=%0d exp=1/1",
               pc_en, stall_cycles);
    end
    tick();
  endtask

  task automatic test_zero_unused();
    ex_mem_read = 1; ex_write_reg = 0; id_rs = 0; id_uses_rs = 1;
    @(negedge clk);
    checks++;
    if (pc_en !== 1 || idex_flush !== 0) begin
      errors++;
      $display("FAIL load_zero pc_en=%b idex_flush=%b exp=1/0",
               pc_en, idex_flush);
    end
    tick();
    idle_in();
    ex_mem_read = 1; ex_write_reg = 9; id_rt = 9; id_uses_rt = 0;
    id_rs = 9; id_uses_rs = 0;
    @(negedge clk);
    checks++;
    if (pc_en !== 1 || idex_flush !== 0) begin
      errors++;
      $display("FAIL load_unused pc_en=%b idex_flush=%b exp=1/0",
               pc_en, idex_flush);
    end
    tick();
    idle_in();
  endtask

  task automatic test_redirect_over_hazard();
    clear_cnt();
    ex_mem_read = 1; ex_write_reg = 3; id_rt = 3; id_uses_rt = 1;
    ex_redirect = 1;
    @(negedge clk);
    checks++;
    if (obs !== 8'b1111_1000) begin
      errors++;
      $display("FAIL redirect_prio obs=%b exp=%b", obs, 8'b1111_1000);
    end
    tick();
    idle_in();
    @(negedge clk);
    checks++;
    if (flush_events !== 1 || stall_cycles !== 0) begin
      errors++;
      $display("FAIL redirect_cnt flush=%0d stall=%0d exp=1/0",
               flush_events, stall_cycles);
    end
    tick();
  endtask

  task automatic test_mdu();
    logic [7:0] want [1:5];
    want[1] = 8'b0000_0100;
    want[2] = 8'b0000_0110;
    want[3] = 8'b0000_0110;
    want[4] = 8'b0000_0111;
    want[5] = 8'b1101_0000;
    clear_cnt();
    for (int c = 1; c <= 5; c++) begin
      idle_in();
      if (c == 1) ex_mdu_start = 1;
      if (c == 3) ex_redirect = 1;
      @(negedge clk);
      checks++;
      if (obs !== want[c] || obs !== model_out()) begin
        errors++;
        $display("FAIL mdu_cycle%0d obs=%b exp=%b", c, obs, want[c]);
      end
      tick();
    end
    idle_in();
    @(negedge clk);
    checks++;
    if (stall_cycles !== 4 || flush_events !== 0) begin
      errors++;
      $display("FAIL mdu_cnt stall=%0d flush=%0d exp=4/0",
               stall_cycles, flush_events);
    end
    tick();
  endtask

  task automatic test_reset_mid_mdu();
    idle_in();
    ex_mdu_start = 1;
    tick();
    idle_in();
    tick();
    @(negedge clk);
    #1 reset = 1;
    m_left = 0; m_stall = 0; m_flush = 0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_mdu obs=%b exp=%b", obs, 8'h00);
    end
    tick();
    reset = 0;
    @(negedge clk);
    checks++;
    if (obs !== 8'b1101_0000) begin
      errors++;
      $display("FAIL reset_mdu_run obs=%b exp=%b", obs, 8'b1101_0000);
    end
    tick();
  endtask

  task automatic test_saturation();
    clear_cnt();
    ex_mem_read = 1; ex_write_reg = 7; id_rs = 7; id_uses_rs = 1;
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (stall_cycles !== 4'd15) begin
      errors++;
      $display("FAIL sat stall=%0d exp=15", stall_cycles);
    end
    clear_counters = 1;
    tick();
    clear_counters = 0;
    @(negedge clk);
    checks++;
    if (stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL sat_clear stall=%0d exp=0", stall_cycles);
    end
    tick();
    idle_in();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom);
      id_uses_rt = 1'($urandom);
      ex_mem_read = 1'($urandom);
      ex_write_reg = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 7) == 0);
      ex_mdu_start = ($urandom_range(0, 9) == 0);
      clear_counters = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      exp_o = model_out();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL rand_out i=%0d obs=%b exp=%b", i, obs, exp_o);
      end
      checks++;
      if (stall_cycles !== 4'(m_stall) || flush_events !== 4'(m_flush)) begin
        errors++;
        $display("FAIL rand_cnt i=%0d stall=%0d/%0d flush=%0d/%0d",
                 i, stall_cycles, m_stall, flush_events, m_flush);
      end
      tick();
    end
    idle_in();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_zero_unused();
    test_redirect_over_hazard();
    test_mdu();
    test_reset_mid_mdu();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
